// File: rtl/cam_cfg_pkg.sv
// Shared definitions for the camera configuration sequencer and its ROM.
// The ROM image is built with the same token constants.
package cam_cfg_pkg;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      DECODE,
      SEND,
      WAIT_DONE,
      DELAY,
      ADVANCE,
      DONE
   } cfg_state_t;

   localparam logic [15:0] CFG_DELAY_TOKEN = 16'hFF_F0;
   localparam logic [15:0] CFG_END_TOKEN   = 16'hFF_FF;
   localparam logic [7:0]  CFG_LAST_ADDR   = 8'hFF;

endpackage

// File: rtl/cam_cfg_delay_timer.sv
// Loadable down-counter used for the wait entries of the configuration table.
// A load of DELAY_CYCLES-1 followed by decrements gives DELAY_CYCLES cycles until zero.
module cam_cfg_delay_timer #(
   parameter int DELAY_CYCLES = 250_000
) (
   input  logic i_clk,
   input  logic i_rstn,
   input  logic i_load,
   input  logic i_dec,
   output logic o_zero
);

   localparam int CW = $clog2(DELAY_CYCLES + 1);
   localparam logic [CW-1:0] LOAD_VALUE = CW'(DELAY_CYCLES - 1);

   logic [CW-1:0] count;

   // The counter parks at zero so a stray decrement request cannot wrap it.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         count <= '0;
      end else if (i_load) begin
         count <= LOAD_VALUE;
      end else if (i_dec && (count != '0)) begin
         count <= count - CW'(1);
      end
   end

   assign o_zero = (count == '0);

endmodule

// File: rtl/cam_cfg_sequencer.sv
// Walks the camera configuration ROM and turns each entry into an SCCB write,
// a fixed wait, or the end of configuration (raising o_done).
module cam_cfg_sequencer
   import cam_cfg_pkg::*;
#(
   parameter int CLK_FREQ     = 25_000_000,
   parameter int DELAY_MS     = 10,
   parameter int DELAY_CYCLES = CLK_FREQ / 1000 * DELAY_MS
) (
   input  logic        i_clk,
   input  logic        i_rstn,
   input  logic        i_start,
   output logic [7:0]  o_rom_addr,
   input  logic [15:0] i_rom_data,
   output logic        o_sccb_valid,
   output logic [7:0]  o_sccb_reg,
   output logic [7:0]  o_sccb_val,
   input  logic        i_sccb_ready,
   input  logic        i_sccb_done,
   output logic        o_busy,
   output logic        o_done
);

   cfg_state_t state;
   logic       timer_load;
   logic       timer_dec;
   logic       timer_zero;

   assign timer_load = (state == DECODE) && (i_rom_data == CFG_DELAY_TOKEN);
   assign timer_dec  = (state == DELAY);

   cam_cfg_delay_timer #(
      .DELAY_CYCLES(DELAY_CYCLES)
   ) u_delay_timer (
      .i_clk (i_clk),
      .i_rstn(i_rstn),
      .i_load(timer_load),
      .i_dec (timer_dec),
      .o_zero(timer_zero)
   );

   // Main sequencing FSM; the ROM is read in FETCH and its data decoded one cycle later.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state        <= IDLE;
         o_rom_addr   <= '0;
         o_sccb_valid <= 1'b0;
         o_sccb_reg   <= '0;
         o_sccb_val   <= '0;
         o_busy       <= 1'b0;
         o_done       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (i_start) begin
                  o_rom_addr <= '0;
                  o_busy     <= 1'b1;
                  state      <= FETCH;
               end
            end
            FETCH: begin
               state <= DECODE;
            end
            DECODE: begin
               if (i_rom_data == CFG_END_TOKEN) begin
                  o_busy <= 1'b0;
                  o_done <= 1'b1;
                  state  <= DONE;
               end else if (i_rom_data == CFG_DELAY_TOKEN) begin
                  state <= DELAY;
               end else begin
                  o_sccb_reg   <= i_rom_data[15:8];
                  o_sccb_val   <= i_rom_data[7:0];
                  o_sccb_valid <= 1'b1;
                  state        <= SEND;
               end
            end
            SEND: begin
               if (i_sccb_ready) begin
                  o_sccb_valid <= 1'b0;
                  state        <= WAIT_DONE;
               end
            end
            WAIT_DONE: begin
               if (i_sccb_done) begin
                  state <= ADVANCE;
               end
            end
            DELAY: begin
               if (timer_zero) begin
                  state <= ADVANCE;
               end
            end
            // A table with no end token stops at the last address instead of wrapping.
            ADVANCE: begin
               if (o_rom_addr == CFG_LAST_ADDR) begin
                  o_busy <= 1'b0;
                  o_done <= 1'b1;
                  state  <= DONE;
               end else begin
                  o_rom_addr <= o_rom_addr + 8'd1;
                  state      <= FETCH;
               end
            end
            DONE: begin
               if (i_start) begin
                  o_done     <= 1'b0;
                  o_rom_addr <= '0;
                  o_busy     <= 1'b1;
                  state      <= FETCH;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cam_cfg_sequencer.sv
// Self-checking bench for cam_cfg_sequencer with a registered ROM model,
// an SCCB master model and a table-walking reference model.
module tb_cam_cfg_sequencer;

   localparam int DCYC = 8;

   logic        i_clk = 1'b0;
   logic        i_rstn = 1'b0;
   logic        i_start = 1'b0;
   logic [7:0]  o_rom_addr;
   logic [15:0] rom_q;
   logic        o_sccb_valid;
   logic [7:0]  o_sccb_reg;
   logic [7:0]  o_sccb_val;
   logic        i_sccb_ready = 1'b1;
   logic        i_sccb_done = 1'b0;
   logic        o_busy;
   logic        o_done;

   int total = 0;
   int bad = 0;

   logic [15:0] rom [256];

   logic [15:0] wr_q[$];
   logic [7:0]  wr_addr_q[$];
   int          gap_q[$];
   logic [16:0] stall_q[$];
   int          done_cnt = 0;
   int          done_lat = 3;
   int          stall_left = 0;
   int          ready_mode = 0;
   int          since_done = 0;
   bit          armed = 0;
   bit          addr_back = 0;
   logic        prev_busy = 1'b0;
   logic [7:0]  prev_addr = 8'd0;

   logic [15:0] exp_wr[$];
   logic [7:0]  exp_addr[$];
   int          exp_gap[$];
   int          exp_end_addr;

   cam_cfg_sequencer #(
      .DELAY_CYCLES(DCYC)
   ) dut (
      .i_clk       (i_clk),
      .i_rstn      (i_rstn),
      .i_start     (i_start),
      .o_rom_addr  (o_rom_addr),
      .i_rom_data  (rom_q),
      .o_sccb_valid(o_sccb_valid),
      .o_sccb_reg  (o_sccb_reg),
      .o_sccb_val  (o_sccb_val),
      .i_sccb_ready(i_sccb_ready),
      .i_sccb_done (i_sccb_done),
      .o_busy      (o_busy),
      .o_done      (o_done)
   );

   always #5 i_clk = ~i_clk;

   // Registered ROM: one cycle read latency.
   always @(posedge i_clk) rom_q <= rom[o_rom_addr];

   // SCCB master model plus transfer logger, working on the falling edge.
   always @(negedge i_clk) begin
      if (armed) begin
         if (o_sccb_valid) begin
            gap_q.push_back(since_done);
            armed = 0;
         end else begin
            since_done++;
         end
      end
      i_sccb_done = 1'b0;
      if (done_cnt > 0) begin
         done_cnt--;
         if (done_cnt == 0) begin
            i_sccb_done = 1'b1;
            armed = 1;
            since_done = 0;
         end
      end
      if (o_sccb_valid && stall_left > 0) begin
         i_sccb_ready = 1'b0;
         stall_left--;
         stall_q.push_back({o_sccb_valid, o_sccb_reg, o_sccb_val});
      end else begin
         i_sccb_ready = (ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      end
      if (o_sccb_valid && i_sccb_ready) begin
         wr_q.push_back({o_sccb_reg, o_sccb_val});
         wr_addr_q.push_back(o_rom_addr);
         done_cnt = done_lat;
      end
      if (prev_busy && o_busy && (o_rom_addr < prev_addr)) addr_back = 1;
      prev_busy = o_busy;
      prev_addr = o_rom_addr;
   end

   // Reference: walk the table by its rules and list expected writes and spacing.
   task automatic build_model();
      int nd;
      bit first;
      nd = 0;
      first = 1;
      exp_wr.delete();
      exp_addr.delete();
      exp_gap.delete();
      exp_end_addr = 255;
      for (int a = 0; a < 256; a++) begin
         if (rom[a] == 16'hFFFF) begin
            exp_end_addr = a;
            break;
         end
         if (rom[a] == 16'hFFF0) begin
            nd++;
         end else begin
            exp_wr.push_back(rom[a]);
            exp_addr.push_back(8'(a));
            if (!first) exp_gap.push_back(3 + nd * (DCYC + 3));
            first = 0;
            nd = 0;
         end
      end
   endtask

   task automatic load_basic_rom();
      for (int a = 0; a < 256; a++) rom[a] = 16'hFFFF;
      rom[0] = 16'h1280;
      rom[1] = 16'hFFF0;
      rom[2] = 16'h1180;
      rom[3] = 16'hFFFF;
   endtask

   task automatic begin_run();
      wr_q.delete();
      wr_addr_q.delete();
      gap_q.delete();
      stall_q.delete();
      armed = 0;
      done_cnt = 0;
      addr_back = 0;
      i_start = 1'b1;
      @(posedge i_clk); #1;
      i_start = 1'b0;
   endtask

   task automatic wait_done(input int max_cycles, output bit ok);
      for (int c = 0; c < max_cycles; c++) begin
         if (o_done) break;
         @(posedge i_clk); #1;
      end
      ok = o_done;
   endtask

   task automatic test_reset();
      i_rstn = 1'b0;
      repeat (2) @(posedge i_clk);
      #1;
      total++; if (o_rom_addr !== 8'd0) begin bad++; $display("FAIL reset_addr: got %h want 00", o_rom_addr); end
      total++; if (o_sccb_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", o_sccb_valid); end
      total++; if ({o_sccb_reg, o_sccb_val} !== 16'h0) begin bad++; $display("FAIL reset_regval: got %h want 0000", {o_sccb_reg, o_sccb_val}); end
      total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", o_busy); end
      total++; if (o_done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", o_done); end
      i_rstn = 1'b1;
      @(posedge i_clk); #1;
   endtask

   task automatic test_basic();
      bit ok;
      load_basic_rom();
      build_model();
      ready_mode = 0;
      done_lat = 3;
      begin_run();
      total++; if (o_busy !== 1'b1) begin bad++; $display("FAIL basic_busy_start: got %b want 1", o_busy); end
      wait_done(500, ok);
      total++; if (!ok) begin bad++; $display("FAIL basic_timeout: got done=%b want 1", o_done); end
      total++; if (wr_q.size() != exp_wr.size()) begin bad++; $display("FAIL basic_count: got %0d want %0d", wr_q.size(), exp_wr.size()); end
      for (int i = 0; i < exp_wr.size() && i < wr_q.size(); i++) begin
         total++; if (wr_q[i] !== exp_wr[i]) begin bad++; $display("FAIL basic_wr[%0d]: got %h want %h", i, wr_q[i], exp_wr[i]); end
      end
      total++; if (gap_q.size() != 1 || gap_q[0] != exp_gap[0]) begin bad++; $display("FAIL basic_delay_gap: got %p want %p", gap_q, exp_gap); end
      total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL basic_busy_end: got %b want 0", o_busy); end
      total++; if (o_rom_addr !== 8'(exp_end_addr)) begin bad++; $display("FAIL basic_end_addr: got %h want %h", o_rom_addr, 8'(exp_end_addr)); end
   endtask

   task automatic test_restart();
      bit ok;
      build_model();
      begin_run();
      total++; if (o_done !== 1'b0) begin bad++; $display("FAIL restart_done_drop: got %b want 0", o_done); end
      total++; if (o_rom_addr !== 8'd0) begin bad++; $display("FAIL restart_addr: got %h want 00", o_rom_addr); end
      wait_done(500, ok);
      total++; if (!ok) begin bad++; $display("FAIL restart_timeout: got done=%b want 1", o_done); end
      total++; if (wr_q.size() != exp_wr.size()) begin bad++; $display("FAIL restart_count: got %0d want %0d", wr_q.size(), exp_wr.size()); end
      for (int i = 0; i < exp_wr.size() && i < wr_q.size(); i++) begin
         total++; if (wr_q[i] !== exp_wr[i]) begin bad++; $display("FAIL restart_wr[%0d]: got %h want %h", i, wr_q[i], exp_wr[i]); end
      end
   endtask

   task automatic test_backpressure();
      bit ok;
      build_model();
      stall_left = 5;
      begin_run();
      wait_done(500, ok);
      total++; if (!ok) begin bad++; $display("FAIL bp_timeout: got done=%b want 1", o_done); end
      total++; if (stall_q.size() != 5) begin bad++; $display("FAIL bp_stall_cycles: got %0d want 5", stall_q.size()); end
      for (int i = 0; i < stall_q.size(); i++) begin
         total++; if (stall_q[i] !== 17'h1_1280) begin bad++; $display("FAIL bp_hold[%0d]: got %h want 11280", i, stall_q[i]); end
      end
      total++; if (wr_q.size() != 2) begin bad++; $display("FAIL bp_count: got %0d want 2", wr_q.size()); end
      total++; if (wr_q.size() > 0 && wr_q[0] !== 16'h1280) begin bad++; $display("FAIL bp_first: got %h want 1280", wr_q[0]); end
      stall_left = 0;
   endtask

   task automatic test_start_ignored();
      bit ok;
      bit seen;
      build_model();
      begin_run();
      seen = 0;
      for (int c = 0; c < 200; c++) begin
         @(posedge i_clk); #1;
         if (o_sccb_valid && o_sccb_reg == 8'h11) begin
            seen = 1;
            break;
         end
      end
      total++; if (!seen) begin bad++; $display("FAIL ign_reach_send: got valid=%b reg=%h want 1/11", o_sccb_valid, o_sccb_reg); end
      i_start = 1'b1;
      @(posedge i_clk); #1;
      i_start = 1'b0;
      wait_done(500, ok);
      total++; if (!ok) begin bad++; $display("FAIL ign_timeout: got done=%b want 1", o_done); end
      total++; if (wr_q.size() != exp_wr.size()) begin bad++; $display("FAIL ign_count: got %0d want %0d", wr_q.size(), exp_wr.size()); end
      for (int i = 0; i < exp_wr.size() && i < wr_q.size(); i++) begin
         total++; if (wr_q[i] !== exp_wr[i]) begin bad++; $display("FAIL ign_wr[%0d]: got %h want %h", i, wr_q[i], exp_wr[i]); end
      end
   endtask

   task automatic test_no_end();
      bit ok;
      int addr_errs;
      for (int a = 0; a < 256; a++) rom[a] = 16'h0102;
      build_model();
      done_lat = 1;
      begin_run();
      wait_done(20000, ok);
      total++; if (!ok) begin bad++; $display("FAIL noend_timeout: got done=%b want 1", o_done); end
      total++; if (wr_q.size() != 256) begin bad++; $display("FAIL noend_count: got %0d want 256", wr_q.size()); end
      addr_errs = 0;
      for (int i = 0; i < wr_addr_q.size() && i < exp_addr.size(); i++)
         if (wr_addr_q[i] !== exp_addr[i] || wr_q[i] !== exp_wr[i]) addr_errs++;
      total++; if (addr_errs != 0) begin bad++; $display("FAIL noend_addrs: got %0d bad entries want 0", addr_errs); end
      total++; if (o_rom_addr !== 8'hFF) begin bad++; $display("FAIL noend_final_addr: got %h want ff", o_rom_addr); end
      total++; if (addr_back) begin bad++; $display("FAIL noend_wrap: got address decrease want none"); end
      total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL noend_busy: got %b want 0", o_busy); end
      done_lat = 3;
   endtask

   task automatic test_reset_in_delay();
      bit seen;
      load_basic_rom();
      begin_run();
      seen = 0;
      for (int c = 0; c < 200; c++) begin
         @(posedge i_clk); #1;
         if (i_sccb_done) begin
            seen = 1;
            break;
         end
      end
      total++; if (!seen) begin bad++; $display("FAIL rstdly_first_done: got none want pulse"); end
      repeat (4) @(posedge i_clk);
      #1;
      i_rstn = 1'b0;
      #1;
      total++; if ({o_sccb_valid, o_busy, o_done} !== 3'b000) begin bad++; $display("FAIL rstdly_flags: got %b want 000", {o_sccb_valid, o_busy, o_done}); end
      total++; if ({o_rom_addr, o_sccb_reg, o_sccb_val} !== 24'h0) begin bad++; $display("FAIL rstdly_data: got %h want 000000", {o_rom_addr, o_sccb_reg, o_sccb_val}); end
      @(posedge i_clk); #1;
      i_rstn = 1'b1;
      repeat (30) @(posedge i_clk);
      #1;
      total++; if (wr_q.size() != 1) begin bad++; $display("FAIL rstdly_no_writes: got %0d want 1", wr_q.size()); end
      total++; if (o_busy !== 1'b0 || o_done !== 1'b0) begin bad++; $display("FAIL rstdly_idle: got busy=%b done=%b want 0/0", o_busy, o_done); end
   endtask

   task automatic test_random();
      bit ok;
      int n;
      int r;
      logic [15:0] w;
      ready_mode = 1;
      for (int it = 0; it < 6; it++) begin
         for (int a = 0; a < 256; a++) rom[a] = 16'hFFFF;
         n = $urandom_range(1, 10);
         for (int i = 0; i < n; i++) begin
            r = $urandom_range(0, 5);
            if (r == 0) begin
               w = 16'hFFF0;
            end else if (r == 1) begin
               w = {8'hFF, 8'($urandom_range(0, 8'hEF))};
            end else begin
               w = 16'($urandom_range(0, 16'hFEFF));
            end
            rom[i] = w;
         end
         build_model();
         done_lat = $urandom_range(1, 4);
         begin_run();
         wait_done(2000, ok);
         total++; if (!ok) begin bad++; $display("FAIL rand%0d_timeout: got done=%b want 1", it, o_done); end
         total++; if (wr_q.size() != exp_wr.size()) begin bad++; $display("FAIL rand%0d_count: got %0d want %0d", it, wr_q.size(), exp_wr.size()); end
         for (int i = 0; i < exp_wr.size() && i < wr_q.size(); i++) begin
            total++; if (wr_q[i] !== exp_wr[i]) begin bad++; $display("FAIL rand%0d_wr[%0d]: got %h want %h", it, i, wr_q[i], exp_wr[i]); end
         end
         total++; if (gap_q != exp_gap) begin bad++; $display("FAIL rand%0d_gaps: got %p want %p", it, gap_q, exp_gap); end
         total++; if (o_rom_addr !== 8'(exp_end_addr)) begin bad++; $display("FAIL rand%0d_end_addr: got %h want %h", it, o_rom_addr, 8'(exp_end_addr)); end
      end
      ready_mode = 0;
      done_lat = 3;
   endtask

   initial begin
      for (int a = 0; a < 256; a++) rom[a] = 16'hFFFF;
      test_reset();
      test_basic();
      test_restart();
      test_backpressure();
      test_start_ignored();
      test_no_end();
      test_reset_in_delay();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
